fifo_drain_scheduler: RTL and testbench

Weighted round-robin burst scheduler that drains up to CLIENTS source FIFOs into a single shared sink FIFO. Each grant reads one word from the selected source and writes it to the sink in the same cycle. Each client holds the sink for a programmable burst of words before the next client is considered. It sequences the read side of the per-client FIFOs and the write side of the merge FIFO.

---
 rtl/fifo_drain_sched_pkg.sv | 22 ++
 rtl/fifo_drain_scheduler_rr_next_select.sv | 50 +++++
 rtl/fifo_drain_scheduler.sv | 141 ++++++++++++++
 tb/tb_fifo_drain_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_sched_pkg.sv
// rtl/fifo_drain_sched_pkg.sv - shared types and helpers for the FIFO drain scheduler
//
// Purpose: holds the scheduler state encoding and the zero-weight helper used
// when a burst length is loaded.
// Contents:
//   state_t  - scheduler FSM state (IDLE, BURST)
//   max1()   - returns the weight, or 1 when the weight is 0

package fifo_drain_sched_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   // Works on a 32-bit value so it serves any WEIGHT_W up to 32; callers
   // widen the weight going in and truncate the result coming out.
   function automatic logic [31:0] max1(input logic [31:0] weight);
      return (weight == 32'd0) ? 32'd1 : weight;
   endfunction

endpackage

// File: rtl/fifo_drain_scheduler_rr_next_select.sv
// rtl/fifo_drain_scheduler_rr_next_select.sv - round-robin next-client selector
//
// Purpose: picks the first requesting client strictly after the last owner,
// wrapping around.
// Ports:
//   req   - request vector, bit n = client n wants service
//   last  - index of the client that owned the previous burst
//   next  - selected client index (meaningful only when valid)
//   valid - at least one client is requesting

module rr_next_select #(
   parameter int CLIENTS = 4,
   localparam int IDX_W = (CLIENTS > 1) ? $clog2(CLIENTS) : 1
) (
   input  logic [CLIENTS-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic [IDX_W-1:0]   next,
   output logic               valid
);

   logic [2*CLIENTS-1:0] dbl;
   logic [CLIENTS-1:0]   rot;
   int                   shift;
   int                   off;
   int                   sum;

   // Rotate the request vector so the client right after 'last' lands on
   // bit 0, priority-encode the lowest set bit, then undo the rotation.
   always_comb begin
      shift = int'(last) + 1;
      if (shift >= CLIENTS) begin
         shift = 0;
      end
      dbl   = {req, req} >> shift;
      rot   = dbl[CLIENTS-1:0];
      valid = |req;
      off   = 0;
      for (int i = CLIENTS - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off = i;
         end
      end
      sum = shift + off;
      if (sum >= CLIENTS) begin
         sum = sum - CLIENTS;
      end
      next = IDX_W'(sum);
   end

endmodule

// File: rtl/fifo_drain_scheduler.sv
// rtl/fifo_drain_scheduler.sv - weighted round-robin burst drain of source FIFOs into one sink
//
// Purpose: grants one source FIFO at a time for a burst of up to its weight in
// words, moving one word per grant from the source (FWFT) into the sink.
// Ports:
//   i_clk, i_rst  - clock, synchronous active-high reset
//   i_req         - per-source not-empty flags
//   i_weight      - per-client burst length, client n at [n*WEIGHT_W +: WEIGHT_W]
//   i_data        - per-source FWFT read data, client n at [n*DATA_WIDTH +: DATA_WIDTH]
//   i_block_arb   - holds off the start of a new burst
//   i_sink_full   - sink cannot accept a word this cycle
//   o_gnt         - one-hot source read strobe
//   o_wr          - sink write strobe
//   o_wr_data     - word written to the sink (zero when idle)
//   o_busy        - a burst is in progress
//   o_owner       - client owning the current or most recent burst

module fifo_drain_scheduler
   import fifo_drain_sched_pkg::*;
#(
   parameter int CLIENTS    = 4,
   parameter int WEIGHT_W   = 4,
   parameter int DATA_WIDTH = 8,
   localparam int IDX_W = (CLIENTS > 1) ? $clog2(CLIENTS) : 1
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic [CLIENTS-1:0]             i_req,
   input  logic [CLIENTS*WEIGHT_W-1:0]    i_weight,
   input  logic [CLIENTS*DATA_WIDTH-1:0]  i_data,
   input  logic                           i_block_arb,
   input  logic                           i_sink_full,
   output logic [CLIENTS-1:0]             o_gnt,
   output logic                           o_wr,
   output logic [DATA_WIDTH-1:0]          o_wr_data,
   output logic                           o_busy,
   output logic [IDX_W-1:0]               o_owner
);

   state_t              state;
   logic [IDX_W-1:0]    owner;
   logic [IDX_W-1:0]    last_owner;
   logic [WEIGHT_W-1:0] cnt;
   logic                busy;

   logic [IDX_W-1:0]    sel;
   logic                sel_valid;
   logic [WEIGHT_W-1:0] sel_weight;
   logic                owner_req;

   rr_next_select #(
      .CLIENTS (CLIENTS)
   ) u_next_select (
      .req   (i_req),
      .last  (last_owner),
      .next  (sel),
      .valid (sel_valid)
   );

   always_comb begin
      sel_weight = '0;
      owner_req  = 1'b0;
      for (int i = 0; i < CLIENTS; i++) begin
         if (sel == IDX_W'(i)) begin
            sel_weight = i_weight[i*WEIGHT_W +: WEIGHT_W];
         end
         if (owner == IDX_W'(i)) begin
            owner_req = i_req[i];
         end
      end
   end

   // Grant is gated by i_rst so nothing is read or written in a reset cycle,
   // even though the registered state still shows the old burst.
   always_comb begin
      o_gnt = '0;
      if (!i_rst && (state == BURST) && owner_req && !i_sink_full) begin
         for (int i = 0; i < CLIENTS; i++) begin
            if (owner == IDX_W'(i)) begin
               o_gnt[i] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      o_wr_data = '0;
      for (int i = 0; i < CLIENTS; i++) begin
         o_wr_data = o_wr_data | ({DATA_WIDTH{o_gnt[i]}} & i_data[i*DATA_WIDTH +: DATA_WIDTH]);
      end
   end

   assign o_wr    = |o_gnt;
   assign o_busy  = busy;
   assign o_owner = owner;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= IDLE;
         owner      <= '0;
         last_owner <= IDX_W'(CLIENTS - 1);
         cnt        <= '0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // The sink is deliberately not consulted here; a full sink
               // only pauses the burst once it has started.
               if (!i_block_arb && sel_valid) begin
                  owner <= sel;
                  cnt   <= WEIGHT_W'(max1(32'(sel_weight)));
                  state <= BURST;
                  busy  <= 1'b1;
               end
            end
            BURST: begin
               if (!owner_req) begin
                  last_owner <= owner;
                  state      <= IDLE;
                  busy       <= 1'b0;
               end else if (!i_sink_full) begin
                  // cnt is left at 1 on the final grant rather than
                  // wrapping to 0.
                  if (cnt == WEIGHT_W'(1)) begin
                     last_owner <= owner;
                     state      <= IDLE;
                     busy       <= 1'b0;
                  end else begin
                     cnt <= cnt - WEIGHT_W'(1);
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_drain_scheduler.sv
// tb/tb_fifo_drain_scheduler.sv - self-checking bench for fifo_drain_scheduler
//
// Purpose: drives modelled FWFT sources and checks grant, write strobe and
// write data cycle by cycle against an expected-grant scoreboard.

module tb_fifo_drain_scheduler;

   localparam int CLIENTS    = 4;
   localparam int WEIGHT_W   = 4;
   localparam int DATA_WIDTH = 8;

   logic                           clk = 1'b0;
   logic                           i_rst;
   logic [CLIENTS-1:0]             i_req;
   logic [CLIENTS*WEIGHT_W-1:0]    i_weight;
   logic [CLIENTS*DATA_WIDTH-1:0]  i_data;
   logic                           i_block_arb;
   logic                           i_sink_full;
   logic [CLIENTS-1:0]             o_gnt;
   logic                           o_wr;
   logic [DATA_WIDTH-1:0]          o_wr_data;
   logic                           o_busy;
   logic [1:0]                     o_owner;

   always #5 clk = ~clk;

   fifo_drain_scheduler #(
      .CLIENTS    (CLIENTS),
      .WEIGHT_W   (WEIGHT_W),
      .DATA_WIDTH (DATA_WIDTH)
   ) dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_req       (i_req),
      .i_weight    (i_weight),
      .i_data      (i_data),
      .i_block_arb (i_block_arb),
      .i_sink_full (i_sink_full),
      .o_gnt       (o_gnt),
      .o_wr        (o_wr),
      .o_wr_data   (o_wr_data),
      .o_busy      (o_busy),
      .o_owner     (o_owner)
   );

   int                    depth [CLIENTS];
   logic [DATA_WIDTH-1:0] word  [CLIENTS];
   logic [DATA_WIDTH-1:0] snap  [CLIENTS];
   logic [CLIENTS-1:0]    obs_gnt;
   logic                  obs_wr;
   logic [DATA_WIDTH-1:0] obs_data;
   logic                  obs_busy;
   logic [1:0]            obs_owner;
   logic [CLIENTS-1:0]    sb [$];
   logic [CLIENTS-1:0]    eg;
   logic [DATA_WIDTH-1:0] ed;
   int                    tests = 0;
   int                    fails = 0;

   // One clock: present source state, sample outputs at the falling edge,
   // then pop every source that was granted.
   task automatic step();
      for (int c = 0; c < CLIENTS; c++) begin
         i_req[c] = (depth[c] > 0);
         i_data[c*DATA_WIDTH +: DATA_WIDTH] = word[c];
      end
      @(negedge clk);
      obs_gnt   = o_gnt;
      obs_wr    = o_wr;
      obs_data  = o_wr_data;
      obs_busy  = o_busy;
      obs_owner = o_owner;
      for (int c = 0; c < CLIENTS; c++) snap[c] = word[c];
      @(posedge clk);
      #1;
      for (int c = 0; c < CLIENTS; c++) begin
         if (obs_gnt[c]) begin
            depth[c] = depth[c] - 1;
            word[c]  = word[c] + 1'b1;
         end
      end
   endtask

   task automatic do_reset();
      i_rst       = 1'b1;
      i_block_arb = 1'b0;
      i_sink_full = 1'b0;
      i_weight    = '0;
      for (int c = 0; c < CLIENTS; c++) begin
         depth[c] = 0;
         word[c]  = DATA_WIDTH'(c * 64);
      end
      step();
      step();
      i_rst = 1'b0;
      sb.delete();
   endtask

   function automatic logic [CLIENTS-1:0] onehot(input int c);
      return (c < 0) ? '0 : CLIENTS'(1 << c);
   endfunction

   task automatic test_reset();
      do_reset();
      i_rst    = 1'b1;
      depth[0] = 100;
      step();
      tests++;
      if ({obs_gnt, obs_wr, obs_data, obs_busy, obs_owner} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: gnt/wr/data/busy/owner got %b/%b/%h/%b/%0d want 0/0/00/0/0",
                  obs_gnt, obs_wr, obs_data, obs_busy, obs_owner);
      end
      i_rst = 1'b0;
   endtask

   task automatic test_single_client();
      int seq [9] = '{-1, 0, 0, 0, -1, 0, 0, -1, -1};
      do_reset();
      i_weight[0 +: WEIGHT_W] = 4'd3;
      depth[0] = 5;
      foreach (seq[i]) sb.push_back(onehot(seq[i]));
      for (int k = 0; k < 9; k++) begin
         step();
         eg = sb.pop_front();
         ed = '0;
         for (int c = 0; c < CLIENTS; c++) if (eg[c]) ed = snap[c];
         tests++;
         if ({obs_gnt, obs_wr, obs_data} !== {eg, |eg, ed}) begin
            fails++;
            $display("FAIL single_client cyc %0d: gnt/wr/data got %b/%b/%h want %b/%b/%h",
                     k, obs_gnt, obs_wr, obs_data, eg, |eg, ed);
         end
      end
      tests++;
      if (o_busy !== 1'b0) begin
         fails++;
         $display("FAIL single_client_idle_busy: got %b want 0", o_busy);
      end
   endtask

   task automatic test_weighted_order();
      int seq [16] = '{-1, 0, -1, 1, 1, -1, 2, 2, 2, -1, 3, 3, 3, 3, -1, 0};
      do_reset();
      i_weight = {4'd4, 4'd3, 4'd2, 4'd1};
      for (int c = 0; c < CLIENTS; c++) depth[c] = 100;
      foreach (seq[i]) sb.push_back(onehot(seq[i]));
      for (int k = 0; k < 16; k++) begin
         step();
         eg = sb.pop_front();
         ed = '0;
         for (int c = 0; c < CLIENTS; c++) if (eg[c]) ed = snap[c];
         tests++;
         if ({obs_gnt, obs_wr, obs_data} !== {eg, |eg, ed}) begin
            fails++;
            $display("FAIL weighted_order cyc %0d: gnt/wr/data got %b/%b/%h want %b/%b/%h",
                     k, obs_gnt, obs_wr, obs_data, eg, |eg, ed);
         end
      end
   endtask

   task automatic test_sink_full();
      int seq [10] = '{-1, 1, -1, -1, -1, 1, 1, 1, -1, -1};
      int writes = 0;
      do_reset();
      i_weight[1*WEIGHT_W +: WEIGHT_W] = 4'd4;
      depth[1] = 4;
      foreach (seq[i]) sb.push_back(onehot(seq[i]));
      for (int k = 0; k < 10; k++) begin
         i_sink_full = (k >= 2 && k <= 4);
         step();
         if (obs_wr) writes++;
         eg = sb.pop_front();
         ed = '0;
         for (int c = 0; c < CLIENTS; c++) if (eg[c]) ed = snap[c];
         tests++;
         if ({obs_gnt, obs_wr, obs_data} !== {eg, |eg, ed}) begin
            fails++;
            $display("FAIL sink_full cyc %0d: gnt/wr/data got %b/%b/%h want %b/%b/%h",
                     k, obs_gnt, obs_wr, obs_data, eg, |eg, ed);
         end
         if (k == 3) begin
            tests++;
            if (obs_busy !== 1'b1) begin
               fails++;
               $display("FAIL sink_full_busy: got %b want 1", obs_busy);
            end
         end
      end
      i_sink_full = 1'b0;
      tests++;
      if (writes != 4) begin
         fails++;
         $display("FAIL sink_full_writes: got %0d want 4", writes);
      end
   endtask

   task automatic test_block_arb();
      int seq [15] = '{-1, 0, 0, -1, 1, 1, -1, 2, 2, -1, -1, -1, -1, 3, 3};
      do_reset();
      i_weight = {4'd2, 4'd2, 4'd2, 4'd2};
      for (int c = 0; c < CLIENTS; c++) depth[c] = 100;
      foreach (seq[i]) sb.push_back(onehot(seq[i]));
      for (int k = 0; k < 15; k++) begin
         i_block_arb = (k >= 7 && k <= 11);
         step();
         eg = sb.pop_front();
         ed = '0;
         for (int c = 0; c < CLIENTS; c++) if (eg[c]) ed = snap[c];
         tests++;
         if ({obs_gnt, obs_wr, obs_data} !== {eg, |eg, ed}) begin
            fails++;
            $display("FAIL block_arb cyc %0d: gnt/wr/data got %b/%b/%h want %b/%b/%h",
                     k, obs_gnt, obs_wr, obs_data, eg, |eg, ed);
         end
      end
      tests++;
      if (obs_owner !== 2'd3) begin
         fails++;
         $display("FAIL block_arb_owner: got %0d want 3", obs_owner);
      end
      i_block_arb = 1'b0;
   endtask

   task automatic test_weight_zero();
      int seq [5] = '{-1, 0, -1, 0, -1};
      do_reset();
      depth[0] = 100;
      foreach (seq[i]) sb.push_back(onehot(seq[i]));
      for (int k = 0; k < 5; k++) begin
         step();
         eg = sb.pop_front();
         ed = '0;
         for (int c = 0; c < CLIENTS; c++) if (eg[c]) ed = snap[c];
         tests++;
         if ({obs_gnt, obs_wr, obs_data} !== {eg, |eg, ed}) begin
            fails++;
            $display("FAIL weight_zero cyc %0d: gnt/wr/data got %b/%b/%h want %b/%b/%h",
                     k, obs_gnt, obs_wr, obs_data, eg, |eg, ed);
         end
      end
   endtask

   task automatic test_weight_change();
      int seq [8] = '{-1, 1, 1, 1, -1, 1, -1, 1};
      do_reset();
      i_weight[1*WEIGHT_W +: WEIGHT_W] = 4'd3;
      depth[1] = 100;
      foreach (seq[i]) sb.push_back(onehot(seq[i]));
      for (int k = 0; k < 8; k++) begin
         if (k == 1) i_weight[1*WEIGHT_W +: WEIGHT_W] = 4'd1;
         step();
         eg = sb.pop_front();
         ed = '0;
         for (int c = 0; c < CLIENTS; c++) if (eg[c]) ed = snap[c];
         tests++;
         if ({obs_gnt, obs_wr, obs_data} !== {eg, |eg, ed}) begin
            fails++;
            $display("FAIL weight_change cyc %0d: gnt/wr/data got %b/%b/%h want %b/%b/%h",
                     k, obs_gnt, obs_wr, obs_data, eg, |eg, ed);
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      int seq [7] = '{-1, 0, -1, 1, -1, -1, 0};
      do_reset();
      i_weight = {4'd1, 4'd1, 4'd4, 4'd1};
      depth[0] = 1;
      depth[1] = 100;
      foreach (seq[i]) sb.push_back(onehot(seq[i]));
      for (int k = 0; k < 7; k++) begin
         i_rst = (k == 4);
         if (k == 5) depth[0] = 10;
         step();
         eg = sb.pop_front();
         ed = '0;
         for (int c = 0; c < CLIENTS; c++) if (eg[c]) ed = snap[c];
         tests++;
         if ({obs_gnt, obs_wr, obs_data} !== {eg, |eg, ed}) begin
            fails++;
            $display("FAIL reset_mid_burst cyc %0d: gnt/wr/data got %b/%b/%h want %b/%b/%h",
                     k, obs_gnt, obs_wr, obs_data, eg, |eg, ed);
         end
         if (k == 5) begin
            tests++;
            if ({obs_busy, obs_owner} !== 3'b000) begin
               fails++;
               $display("FAIL reset_mid_burst_state: busy/owner got %b/%0d want 0/0",
                        obs_busy, obs_owner);
            end
         end
      end
      i_rst = 1'b0;
   endtask

   initial begin
      i_rst       = 1'b1;
      i_req       = '0;
      i_weight    = '0;
      i_data      = '0;
      i_block_arb = 1'b0;
      i_sink_full = 1'b0;
      test_reset();
      test_single_client();
      test_weighted_order();
      test_sink_full();
      test_block_arb();
      test_weight_zero();
      test_weight_change();
      test_reset_mid_burst();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
